// File: rtl/rv32_register_file_mp_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | rv32_register_file_mp_if                                                   |
// | Write/read port bundle for the multi-port RV32 register file.              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface rv32_register_file_mp_if #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  parameter int AW     = $clog2(DEPTH)
);
  logic [NUM_WR-1:0]      wr_en;
  logic [NUM_WR*AW-1:0]   wr_sel;
  logic [NUM_WR*XLEN-1:0] wr_data;
  logic [NUM_RD*AW-1:0]   rd_sel;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic                   init_done;

  modport master (
    output wr_en, wr_sel, wr_data, rd_sel,
    input  rd_data, init_done
  );

  modport slave (
    input  wr_en, wr_sel, wr_data, rd_sel,
    output rd_data, init_done
  );
endinterface
`default_nettype wire

// File: rtl/rv32_register_file_mp.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | rv32_register_file_mp                                                      |
// | Multi-port register file: registered reads, write bypass, clear sweep.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rv32_register_file_mp #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rv32_register_file_mp_if.slave bus
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [AW-1:0]          r_ptr;
  logic                   r_init_done;
  logic [NUM_RD*XLEN-1:0] r_rd_data;
  logic [NUM_RD*XLEN-1:0] w_rd_next;
  logic                   w_sweep_last;
  logic [XLEN-1:0]        r_mem [DEPTH];

  assign w_sweep_last = (r_state == ST_INIT) && (r_ptr == AW'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_sweep_last) begin
      w_state_next = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_init_done <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      if (r_state == ST_INIT) begin
        r_ptr <= r_ptr + AW'(1);
      end
      r_init_done <= r_init_done | w_sweep_last;
      r_rd_data   <= (r_state == ST_RUN) ? w_rd_next : '0;
    end
  end

  // The array has no reset; the sweep owns it until RUN. Later ports win on collisions.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_mem[r_ptr] <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (bus.wr_en[k] && !((ZERO_REG != 0) && (bus.wr_sel[k*AW +: AW] == '0))) begin
          r_mem[bus.wr_sel[k*AW +: AW]] <= bus.wr_data[k*XLEN +: XLEN];
        end
      end
    end
  end

  // Per read port: array value, overridden by the newest same-cycle write, then by the zero register.
  always_comb begin
    w_rd_next = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      w_rd_next[j*XLEN +: XLEN] = r_mem[bus.rd_sel[j*AW +: AW]];
      for (int k = 0; k < NUM_WR; k++) begin
        if (bus.wr_en[k] && (bus.wr_sel[k*AW +: AW] == bus.rd_sel[j*AW +: AW])) begin
          w_rd_next[j*XLEN +: XLEN] = bus.wr_data[k*XLEN +: XLEN];
        end
      end
      if ((ZERO_REG != 0) && (bus.rd_sel[j*AW +: AW] == '0)) begin
        w_rd_next[j*XLEN +: XLEN] = '0;
      end
    end
  end

  assign bus.rd_data   = r_rd_data;
  assign bus.init_done = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_rv32_register_file_mp.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rv32_register_file_mp                                                   |
// | Two configurations (4R/2W zero-reg, 2R/1W no zero-reg) against array model.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_rv32_register_file_mp;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [31:0] model_a [32];
  logic [31:0] model_b [32];

  rv32_register_file_mp_if #(.XLEN(32), .DEPTH(32), .NUM_RD(4), .NUM_WR(2)) ifa ();
  rv32_register_file_mp_if #(.XLEN(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(1)) ifb ();

  rv32_register_file_mp #(
    .XLEN(32), .DEPTH(32), .NUM_RD(4), .NUM_WR(2), .ZERO_REG(1)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  rv32_register_file_mp #(
    .XLEN(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(1), .ZERO_REG(0)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_writes();
    ifa.wr_en = '0;
    ifb.wr_en = '0;
  endtask

  task automatic clear_models();
    for (int i = 0; i < 32; i++) begin
      model_a[i] = '0;
      model_b[i] = '0;
    end
  endtask

  task automatic rand_inputs(input int sel_max);
    ifa.wr_en   = 2'($urandom_range(0, 3));
    ifa.wr_data = {$urandom, $urandom};
    for (int k = 0; k < 2; k++) ifa.wr_sel[k*5 +: 5] = 5'($urandom_range(0, sel_max));
    for (int j = 0; j < 4; j++) ifa.rd_sel[j*5 +: 5] = 5'($urandom_range(0, sel_max));
    ifb.wr_en   = 1'($urandom_range(0, 1));
    ifb.wr_data = $urandom;
    ifb.wr_sel  = 5'($urandom_range(0, sel_max));
    for (int j = 0; j < 2; j++) ifb.rd_sel[j*5 +: 5] = 5'($urandom_range(0, sel_max));
  endtask

  // Apply this cycle's writes to the model first; a read then simply sees the updated array.
  task automatic tick();
    logic [127:0] exp_a;
    logic [127:0] exp_b;
    logic [4:0]   s;
    exp_a = '0;
    exp_b = '0;
    for (int k = 0; k < 2; k++) begin
      s = ifa.wr_sel[k*5 +: 5];
      if (ifa.wr_en[k] && s != 5'd0) model_a[s] = ifa.wr_data[k*32 +: 32];
    end
    for (int j = 0; j < 4; j++) begin
      s = ifa.rd_sel[j*5 +: 5];
      exp_a[j*32 +: 32] = (s == 5'd0) ? 32'd0 : model_a[s];
    end
    if (ifb.wr_en[0]) model_b[ifb.wr_sel] = ifb.wr_data;
    for (int j = 0; j < 2; j++) exp_b[j*32 +: 32] = model_b[ifb.rd_sel[j*5 +: 5]];
    @(posedge clk);
    #1;
    chk("rd_a_model", 128'(ifa.rd_data), exp_a);
    chk("rd_b_model", 128'(ifb.rd_data), exp_b);
  endtask

  // Wr pulses during the sweep are random and must be ignored.
  task automatic wait_init(input string tag);
    int n;
    n = 0;
    rand_inputs(31);
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(posedge clk);
      #1;
      if (ifa.init_done) begin
        n = cyc;
        break;
      end
      chk({tag, "_sweep_rd_a"}, 128'(ifa.rd_data), 128'd0);
      chk({tag, "_sweep_rd_b"}, 128'(ifb.rd_data), 128'd0);
      rand_inputs(31);
    end
    idle_writes();
    chk({tag, "_sweep_cycles"}, 128'(n), 128'd32);
    chk({tag, "_init_done_b"}, 128'(ifb.init_done), 128'd1);
    clear_models();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    ifa.wr_en = '0; ifa.wr_sel = '0; ifa.wr_data = '0; ifa.rd_sel = '0;
    ifb.wr_en = '0; ifb.wr_sel = '0; ifb.wr_data = '0; ifb.rd_sel = '0;
    clear_models();

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd_a", 128'(ifa.rd_data), 128'd0);
    chk("reset_rd_b", 128'(ifb.rd_data), 128'd0);
    chk("reset_init_done", 128'({ifa.init_done, ifb.init_done}), 128'd0);

    rst_n = 1'b1;
    wait_init("boot");

    // Every entry reads back zero after the sweep.
    for (int base = 0; base < 32; base += 4) begin
      for (int j = 0; j < 4; j++) ifa.rd_sel[j*5 +: 5] = 5'(base + j);
      for (int j = 0; j < 2; j++) ifb.rd_sel[j*5 +: 5] = 5'(base + j);
      tick();
      chk("clear_a", 128'(ifa.rd_data), 128'd0);
      for (int j = 0; j < 2; j++) ifb.rd_sel[j*5 +: 5] = 5'(base + 2 + j);
      tick();
      chk("clear_b", 128'(ifb.rd_data), 128'd0);
    end

    // Write x5 with same-cycle bypass on port 1, then a normal read on port 0.
    ifa.wr_en = 2'b01; ifa.wr_sel = {5'd0, 5'd5}; ifa.wr_data = {32'd0, 32'hDEAD_BEEF};
    ifa.rd_sel = {5'd0, 5'd0, 5'd5, 5'd0};
    tick();
    chk("bypass_p1", 128'(ifa.rd_data[63:32]), 128'hDEAD_BEEF);
    idle_writes();
    ifa.rd_sel = {5'd0, 5'd0, 5'd0, 5'd5};
    tick();
    chk("read_p0_x5", 128'(ifa.rd_data[31:0]), 128'hDEAD_BEEF);

    // x0 write: dropped with the zero register, kept without it.
    ifa.wr_en = 2'b01; ifa.wr_sel = '0; ifa.wr_data = {32'd0, 32'h1234_5678};
    ifa.rd_sel = '0;
    ifb.wr_en = 1'b1; ifb.wr_sel = '0; ifb.wr_data = 32'h1234_5678; ifb.rd_sel = '0;
    tick();
    chk("x0_same_a", 128'(ifa.rd_data[63:0]), 128'd0);
    chk("x0_same_b", 128'(ifb.rd_data), 128'({2{32'h1234_5678}}));
    idle_writes();
    tick();
    chk("x0_later_a", 128'(ifa.rd_data[63:0]), 128'd0);
    chk("x0_later_b", 128'(ifb.rd_data), 128'({2{32'h1234_5678}}));

    // Two ports to x7: the higher port wins, both in bypass and in the array.
    ifa.wr_en = 2'b11; ifa.wr_sel = {5'd7, 5'd7}; ifa.wr_data = {32'h5555_5555, 32'hAAAA_AAAA};
    ifa.rd_sel = {5'd0, 5'd0, 5'd0, 5'd7};
    tick();
    chk("collide_bypass", 128'(ifa.rd_data[31:0]), 128'h5555_5555);
    idle_writes();
    tick();
    chk("collide_later", 128'(ifa.rd_data[31:0]), 128'h5555_5555);

    // Fill x1..x4, read them across four ports, then all ports on x3.
    ifa.wr_en = 2'b11; ifa.wr_sel = {5'd2, 5'd1}; ifa.wr_data = {32'd2, 32'd1};
    tick();
    ifa.wr_sel = {5'd4, 5'd3}; ifa.wr_data = {32'd4, 32'd3};
    tick();
    idle_writes();
    ifa.rd_sel = {5'd4, 5'd3, 5'd2, 5'd1};
    tick();
    chk("four_ports", 128'(ifa.rd_data), {32'd4, 32'd3, 32'd2, 32'd1});
    ifa.rd_sel = {4{5'd3}};
    tick();
    chk("same_addr", 128'(ifa.rd_data), {4{32'd3}});

    for (int i = 0; i < 300; i++) begin
      rand_inputs((i % 2 == 0) ? 7 : 31);
      tick();
    end

    // Mid-stream reset wipes the outputs at once and reruns the sweep.
    ifa.wr_en = 2'b01; ifa.wr_sel = {5'd0, 5'd9}; ifa.wr_data = {32'd0, 32'hCAFE_F00D};
    ifb.wr_en = 1'b1; ifb.wr_sel = 5'd9; ifb.wr_data = 32'hCAFE_F00D;
    ifa.rd_sel = {4{5'd9}}; ifb.rd_sel = {2{5'd9}};
    tick();
    idle_writes();
    tick();
    chk("x9_before_rst", 128'(ifa.rd_data[31:0]), 128'hCAFE_F00D);
    rst_n = 1'b0;
    #1;
    chk("async_rst_rd_a", 128'(ifa.rd_data), 128'd0);
    chk("async_rst_rd_b", 128'(ifb.rd_data), 128'd0);
    chk("async_rst_done", 128'({ifa.init_done, ifb.init_done}), 128'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_init("rerun");
    ifa.rd_sel = {4{5'd9}}; ifb.rd_sel = {2{5'd9}};
    tick();
    chk("x9_after_rst_a", 128'(ifa.rd_data), 128'd0);
    chk("x9_after_rst_b", 128'(ifb.rd_data), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
